apb_master_bridge: RTL

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_master_bridge.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB master bridge.
package apb_pkg;

  // Bridge FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Number of bits needed to index num_slv slaves
  function automatic int unsigned slv_idx_w(input int unsigned num_slv);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < num_slv) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// APB master bridge: turns a valid/ready command into one APB transfer
// and reports completion with a single-cycle response pulse.
// Optional macro APB_TIMEOUT_EN aborts transfers stuck in ACCESS for
// TIMEOUT_CYC cycles with PREADY low.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_SLV     = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                      PCLK,
  input  logic                      rst,
  input  logic                      TRANSFER,
  output logic                      cmd_ready,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [DATA_W-1:0]         cmd_wdata,
  input  logic                      cmd_write,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic                      PWRITE,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err
);

  localparam int unsigned IDX_W = slv_idx_w(NUM_SLV);

  // Reject parameter sets the bridge cannot implement
  if (NUM_SLV < 2 || (NUM_SLV & (NUM_SLV - 1)) != 0 || (DATA_W % 8) != 0 ||
      TIMEOUT_CYC == 0) begin : g_bad_param
    $error("apb_master_bridge: illegal parameter set");
  end

  apb_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                pwrite_q, pwrite_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [IDX_W-1:0]    sel_idx;
  logic [IDX_W-1:0]    cmd_idx;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;
  logic                accept;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = slv_idx_w(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  // Slave selection comes from the top address bits
  assign sel_idx   = paddr_q[ADDR_W-1 -: IDX_W];
  assign cmd_idx   = cmd_addr[ADDR_W-1 -: IDX_W];
  assign sel_ready = PREADY[sel_idx];
  assign sel_err   = PSLVERR[sel_idx];
  assign accept    = TRANSFER && cmd_ready;

  // Read data mux from the selected slave
  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (IDX_W'(i) == sel_idx) sel_rdata = PRDATA[i*DATA_W +: DATA_W];
    end
  end

  // Command ready: idle, or the completing ACCESS cycle (only comb output)
  always_comb begin
    cmd_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:    cmd_ready = 1'b1;
        ACCESS:  cmd_ready = sel_ready;
        default: cmd_ready = 1'b0;
      endcase
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
    cnt_d       = '0;
`endif

    case (state_q)
      IDLE: begin
        psel_d    = '0;
        penable_d = 1'b0;
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (sel_ready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
          rsp_err_d   = sel_err;
          psel_d      = '0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = '0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // An accepted command always starts a fresh SETUP phase
    if (accept) begin
      paddr_d   = cmd_addr;
      pwdata_d  = cmd_wdata;
      pwrite_d  = cmd_write;
      psel_d    = NUM_SLV'(1) << cmd_idx;
      penable_d = 1'b0;
      state_d   = SETUP;
    end
  end

  // State and output registers
  always_ff @(posedge PCLK) begin
    if (rst) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  // Wait-state counter for the ACCESS timeout
  always_ff @(posedge PCLK) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
